// File: rtl/dma_wr_streamer.sv
// DMA write-path W-channel streamer: pops FIFO beats for one burst command and drives AXI W.
// Optional W back-pressure counter enabled by defining DMA_WR_STALL_CNT_EN.
module dma_wr_streamer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ALEN_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [ALEN_WIDTH-1:0]   cmd_len_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_first_strb_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_last_strb_i,
  input  logic                    fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]   fifo_data_i,
  output logic                    fifo_read_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o,
  output logic                    wlast_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [31:0]             stall_cnt_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = ALEN_WIDTH + 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                 state;
  logic [ALEN_WIDTH-1:0]  len_q;
  logic [STRB_WIDTH-1:0]  first_strb_q;
  logic [STRB_WIDTH-1:0]  last_strb_q;
  logic [CNT_WIDTH-1:0]   issued_q;

  logic                   load_en;
  logic                   is_last;
  logic                   w_done;
  logic [STRB_WIDTH-1:0]  beat_strb;

  assign cmd_ready_o = (state == IDLE);
  assign busy_o      = (state == STREAM);
  assign load_en     = ~wvalid_o | wready_i;
  assign is_last     = (issued_q == CNT_WIDTH'(len_q));
  assign w_done      = wvalid_o & wready_i & wlast_o;

  // Pop gated by reset so an abandoned burst never consumes another FIFO entry.
  assign fifo_read_o = ~rst & (state == STREAM) & load_en & ~fifo_empty_i
                       & (issued_q <= CNT_WIDTH'(len_q));

  // Strobe of the beat currently being loaded.
  always_comb begin
    beat_strb = '1;
    if (len_q == '0) begin
      beat_strb = first_strb_q & last_strb_q;
    end else if (issued_q == '0) begin
      beat_strb = first_strb_q;
    end else if (is_last) begin
      beat_strb = last_strb_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      len_q        <= '0;
      first_strb_q <= '0;
      last_strb_q  <= '0;
      issued_q     <= '0;
      wvalid_o     <= 1'b0;
      wdata_o      <= '0;
      wstrb_o      <= '0;
      wlast_o      <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            len_q        <= cmd_len_i;
            first_strb_q <= cmd_first_strb_i;
            last_strb_q  <= cmd_last_strb_i;
            issued_q     <= '0;
            state        <= STREAM;
          end
        end
        STREAM: begin
          // Output stage reloads only when empty or draining; otherwise holds for AXI stability.
          if (fifo_read_o) begin
            wdata_o  <= fifo_data_i;
            wstrb_o  <= beat_strb;
            wlast_o  <= is_last;
            wvalid_o <= 1'b1;
            issued_q <= issued_q + CNT_WIDTH'(1);
          end else if (load_en) begin
            wvalid_o <= 1'b0;
          end
          if (w_done) begin
            done_o <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMA_WR_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of W back-pressure cycles, cleared when a command is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if ((state == IDLE) && cmd_valid_i) begin
      stall_cnt_q <= '0;
    end else if (wvalid_o && !wready_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dma_wr_streamer.sv
// Directed self-checking bench for dma_wr_streamer with a simple array FIFO model and W-beat monitor.
module tb_dma_wr_streamer;

  logic        clk;
  logic        rst;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [7:0]  cmd_len_i;
  logic [3:0]  cmd_first_strb_i;
  logic [3:0]  cmd_last_strb_i;
  logic        fifo_empty_i;
  logic [31:0] fifo_data_i;
  logic        fifo_read_o;
  logic        wvalid_o;
  logic        wready_i;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wlast_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] stall_cnt_o;

  dma_wr_streamer #(.DATA_WIDTH(32), .ALEN_WIDTH(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid_i      (cmd_valid_i),
    .cmd_ready_o      (cmd_ready_o),
    .cmd_len_i        (cmd_len_i),
    .cmd_first_strb_i (cmd_first_strb_i),
    .cmd_last_strb_i  (cmd_last_strb_i),
    .fifo_empty_i     (fifo_empty_i),
    .fifo_data_i      (fifo_data_i),
    .fifo_read_o      (fifo_read_o),
    .wvalid_o         (wvalid_o),
    .wready_i         (wready_i),
    .wdata_o          (wdata_o),
    .wstrb_o          (wstrb_o),
    .wlast_o          (wlast_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .stall_cnt_o      (stall_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO model: pushes from the stimulus process, pops on the clock edge.
  logic [31:0] fifo_mem [512];
  logic [8:0]  wr_ptr = '0;
  logic [8:0]  rd_ptr = '0;
  int          pop_cnt = 0;
  int          cyc = 0;

  always_comb begin
    fifo_empty_i = (wr_ptr == rd_ptr);
    fifo_data_i  = fifo_mem[rd_ptr];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_read_o) begin
      rd_ptr  <= rd_ptr + 9'd1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  // W-channel monitor, sampled mid-cycle where everything is settled.
  logic [31:0] cap_data [512];
  logic [3:0]  cap_strb [512];
  logic        cap_last [512];
  int          cap_cyc  [512];
  int          cap_n = 0;

  always @(negedge clk) begin
    if (!rst && wvalid_o && wready_i && cap_n < 512) begin
      cap_data[cap_n] <= wdata_o;
      cap_strb[cap_n] <= wstrb_o;
      cap_last[cap_n] <= wlast_o;
      cap_cyc[cap_n]  <= cyc;
      cap_n           <= cap_n + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 9'd1;
  endtask

  task automatic fifo_clear();
    wr_ptr = rd_ptr;
  endtask

  task automatic start_cmd(input logic [7:0] len, input logic [3:0] fs, input logic [3:0] ls);
    cmd_valid_i      = 1'b1;
    cmd_len_i        = len;
    cmd_first_strb_i = fs;
    cmd_last_strb_i  = ls;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      tick();
      if (done_o) seen = 1'b1;
    end
    check(tag, seen, 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wvalid"}, wvalid_o, 1'b0);
    check({tag, "_wlast"}, wlast_o, 1'b0);
    check({tag, "_wdata"}, wdata_o, 32'h0);
    check({tag, "_wstrb"}, wstrb_o, 4'h0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_cmd_ready"}, cmd_ready_o, 1'b1);
    check({tag, "_stall"}, stall_cnt_o, 32'h0);
    check({tag, "_fifo_read"}, fifo_read_o, 1'b0);
  endtask

  logic [3:0]  exp_strb4 [4] = '{4'hC, 4'hF, 4'hF, 4'h3};
  int          pb;
  int          cb;
  int          errs;
  int          lasts;
  logic [31:0] sd;
  logic [3:0]  ss;
  logic        sl;
  logic [31:0] exp_stall;

  initial begin
    rst              = 1'b1;
    cmd_valid_i      = 1'b0;
    cmd_len_i        = '0;
    cmd_first_strb_i = '0;
    cmd_last_strb_i  = '0;
    wready_i         = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Single-beat burst: strobe is first & last.
    push(32'hA5A5A5A5);
    pb = pop_cnt;
    wready_i = 1'b1;
    start_cmd(8'd0, 4'hE, 4'h7);
    check("t1_cmd_ready_low", cmd_ready_o, 1'b0);
    check("t1_busy", busy_o, 1'b1);
    check("t1_pop_t1", fifo_read_o, 1'b1);
    tick();
    check("t1_wvalid", wvalid_o, 1'b1);
    check("t1_wdata", wdata_o, 32'hA5A5A5A5);
    check("t1_wstrb", wstrb_o, 4'h6);
    check("t1_wlast", wlast_o, 1'b1);
    tick();
    check("t1_done", done_o, 1'b1);
    check("t1_wvalid_drop", wvalid_o, 1'b0);
    check("t1_busy_drop", busy_o, 1'b0);
    tick();
    check("t1_done_pulse", done_o, 1'b0);
    check("t1_pops", pop_cnt - pb, 1);

    // Four-beat burst, full throughput.
    for (int i = 1; i <= 4; i++) push(32'(i));
    pb = pop_cnt;
    cb = cap_n;
    start_cmd(8'd3, 4'hC, 4'h3);
    wait_done("t2_done", 50);
    check("t2_beats", cap_n - cb, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_data%0d", i), cap_data[cb+i], 32'(i + 1));
      check($sformatf("t2_strb%0d", i), cap_strb[cb+i], exp_strb4[i]);
      check($sformatf("t2_last%0d", i), cap_last[cb+i], (i == 3));
    end
    check("t2_back_to_back", cap_cyc[cb+3] - cap_cyc[cb], 3);
    check("t2_pops", pop_cnt - pb, 4);

    // Back-pressure: 3 stalled cycles on the first beat.
    push(32'h11);
    push(32'h22);
    pb = pop_cnt;
    cb = cap_n;
    wready_i = 1'b0;
    start_cmd(8'd1, 4'h3, 4'hC);
    tick();
    check("t3_wvalid", wvalid_o, 1'b1);
    sd = wdata_o;
    ss = wstrb_o;
    sl = wlast_o;
    check("t3_first_data", sd, 32'h11);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t3_hold_valid%0d", k), wvalid_o, 1'b1);
      check($sformatf("t3_hold_data%0d", k), wdata_o, sd);
      check($sformatf("t3_hold_strb%0d", k), wstrb_o, ss);
      check($sformatf("t3_hold_last%0d", k), wlast_o, sl);
    end
    check("t3_no_extra_pop", pop_cnt - pb, 1);
    wready_i = 1'b1;
    wait_done("t3_done", 20);
    check("t3_beats", cap_n - cb, 2);
    check("t3_strb0", cap_strb[cb], 4'h3);
    check("t3_last0", cap_last[cb], 1'b0);
    check("t3_data1", cap_data[cb+1], 32'h22);
    check("t3_strb1", cap_strb[cb+1], 4'hC);
    check("t3_last1", cap_last[cb+1], 1'b1);
    check("t3_pops", pop_cnt - pb, 2);
`ifdef DMA_WR_STALL_CNT_EN
    exp_stall = 32'd3;
`else
    exp_stall = 32'd0;
`endif
    check("t3_stall_cnt", stall_cnt_o, exp_stall);
    repeat (2) tick();
    check("t3_stall_hold", stall_cnt_o, exp_stall);

    // Underrun: two beats, five empty cycles, two more beats.
    push(32'h31);
    push(32'h32);
    pb = pop_cnt;
    cb = cap_n;
    start_cmd(8'd3, 4'hF, 4'hF);
    repeat (7) tick();
    push(32'h33);
    push(32'h34);
    wait_done("t4_done", 30);
    check("t4_beats", cap_n - cb, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t4_data%0d", i), cap_data[cb+i], 32'h31 + 32'(i));
    check("t4_gap", cap_cyc[cb+2] - cap_cyc[cb+1], 6);
    check("t4_pops", pop_cnt - pb, 4);

    // Max length with a spare word left in the FIFO.
    for (int i = 0; i < 257; i++) push(32'h1000 + 32'(i));
    pb = pop_cnt;
    cb = cap_n;
    start_cmd(8'd255, 4'hF, 4'hF);
    wait_done("t5_done", 1000);
    check("t5_beats", cap_n - cb, 256);
    errs  = 0;
    lasts = 0;
    for (int i = 0; i < 256; i++) begin
      if (cap_data[cb+i] !== 32'h1000 + 32'(i)) errs++;
      if (cap_last[cb+i]) lasts++;
    end
    check("t5_data_errs", errs, 0);
    check("t5_last_count", lasts, 1);
    check("t5_last_beat", cap_last[cb+255], 1'b1);
    check("t5_pops", pop_cnt - pb, 256);
    repeat (3) tick();
    check("t5_no_257th_pop", pop_cnt - pb, 256);
    check("t5_idle", cmd_ready_o, 1'b1);
    fifo_clear();

    // Reset mid-burst on beat 2 of an 8-beat burst.
    for (int i = 0; i < 8; i++) push(32'h700 + 32'(i));
    pb = pop_cnt;
    start_cmd(8'd7, 4'hF, 4'hF);
    repeat (2) tick();
    check("t6_beat2", wdata_o, 32'h701);
    rst = 1'b1;
    tick();
    check_idle_outputs("t6_rst");
    rst = 1'b0;
    check("t6_pops", pop_cnt - pb, 2);
    fifo_clear();
    tick();
    push(32'h5A5A);
    pb = pop_cnt;
    cb = cap_n;
    start_cmd(8'd0, 4'hF, 4'h3);
    wait_done("t6_new_done", 20);
    check("t6_new_beats", cap_n - cb, 1);
    check("t6_new_data", cap_data[cb], 32'h5A5A);
    check("t6_new_strb", cap_strb[cb], 4'h3);
    check("t6_new_last", cap_last[cb], 1'b1);
    check("t6_new_pops", pop_cnt - pb, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
